// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES-128 context/core between NREQ requesters.
// Optional RUN-state watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_job_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*128-1:0]  req_data,
  input  logic [NREQ*128-1:0]  req_key,
  output logic [NREQ-1:0]      gnt,
  output logic                 core_start,
  output logic [127:0]         core_in,
  output logic [127:0]         core_key,
  input  logic                 core_done,
  input  logic [127:0]         core_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [127:0]         rsp_data,
  output logic                 rsp_err
);

  localparam int unsigned CW = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      ptr;
  logic [CW-1:0]   run_cnt;
  logic [2:0]      winner;
  logic            any_req;
  logic            done_q;
  logic            timeout_hit;
  logic [2*NREQ-1:0] req_rot;
  int unsigned     off;
  int unsigned     sum;

  // Rotate the request vector so bit 0 is the requester at ptr, then take the lowest set bit.
  always_comb begin
    any_req = 1'b0;
    off     = 0;
    sum     = 0;
    winner  = '0;
    req_rot = {req, req} >> ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && req_rot[i]) begin
        any_req = 1'b1;
        off     = i;
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    winner = 3'(sum);
  end

  // done is stale on the first RUN cycle: the context only refreshes it while start is high.
  assign done_q = core_done && (run_cnt != '0);

`ifdef AES_ARB_TIMEOUT_EN
  assign timeout_hit = (state == RUN) && !done_q && (run_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (rstn && any_req) begin
          gnt       = {{(NREQ-1){1'b0}}, 1'b1} << winner;
          state_nxt = RUN;
        end
      end
      RUN: begin
        core_start = rstn && !done_q && !timeout_hit;
        if (done_q || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      run_cnt  <= '0;
      core_in  <= '0;
      core_key <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            core_in  <= req_data[128*winner +: 128];
            core_key <= req_key[128*winner +: 128];
            rsp_id   <= winner;
            ptr      <= (winner == 3'(NREQ - 1)) ? '0 : winner + 3'd1;
            run_cnt  <= '0;
          end
        end
        RUN: begin
          if (done_q) rsp_data <= core_out;
          else if (timeout_hit) rsp_data <= '0;
          if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_err <= 1'b0;
    end else if (state == RUN) begin
      if (done_q) rsp_err <= 1'b0;
      else if (timeout_hit) rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: behavioural context/core model plus
// a round-robin reference model driven by directed and randomized jobs.
module tb_aes_job_arbiter;
  localparam int unsigned NREQ = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NREQ-1:0]     req;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ*128-1:0] req_key;
  logic [NREQ-1:0]     gnt;
  logic                core_start;
  logic [127:0]        core_in;
  logic [127:0]        core_key;
  logic                core_done;
  logic [127:0]        core_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2:0]          rsp_id;
  logic [127:0]        rsp_data;
  logic                rsp_err;

  always #5 clk = ~clk;

  aes_job_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .req_key(req_key),
    .gnt(gnt), .core_start(core_start), .core_in(core_in), .core_key(core_key),
    .core_done(core_done), .core_out(core_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned ptr_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: the FIPS-197 vector maps to its real ciphertext, anything else to a keyed scramble.
  function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  // Context model: 11 start-qualified cycles per job, done only refreshed while start is high.
  logic [3:0]   round;
  logic         done_r;
  logic [127:0] ct_r;
  logic         stuck;

  always @(posedge clk) begin
    if (!rstn) begin
      round  <= 4'd0;
      done_r <= 1'b0;
      ct_r   <= '0;
    end else if (core_start && !stuck) begin
      if (round == 4'd10) begin
        round  <= 4'd0;
        done_r <= 1'b1;
        ct_r   <= cipher(core_in, core_key);
      end else begin
        round  <= round + 4'd1;
        done_r <= 1'b0;
      end
    end
  end

  assign core_done = stuck ? 1'b0 : done_r;
  assign core_out  = ct_r;

  function automatic int unsigned ref_winner(input logic [NREQ-1:0] r);
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (r[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_inputs();
    for (int unsigned j = 0; j < NREQ * 4; j++) begin
      req_data[j*32 +: 32] = $urandom;
      req_key[j*32 +: 32]  = $urandom;
    end
  endtask

  task automatic do_reset(input logic [NREQ-1:0] r);
    rstn = 1'b0;
    req = r;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 128'(gnt), '0);
    chk("rst_core_start", 128'(core_start), '0);
    chk("rst_rsp_valid", 128'(rsp_valid), '0);
    chk("rst_core_in", core_in, '0);
    chk("rst_core_key", core_key, '0);
    chk("rst_rsp_id", 128'(rsp_id), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_err", 128'(rsp_err), '0);
    rstn = 1'b1;
    ptr_m = 0;
  endtask

  // Enters and leaves at #1 after a negedge in an IDLE cycle.
  task automatic do_job(input logic [NREQ-1:0] r, input int unsigned hold, input bit drop,
                        input bit fips, output int unsigned gcyc, output logic [NREQ-1:0] gseen);
    int unsigned w;
    int unsigned lat;
    int unsigned starts;
    bit got;
    logic [NREQ-1:0] eg;
    logic [127:0] pt, key, exp_ct;
    w = ref_winner(r);
    rand_inputs();
    if (fips) begin
      req_data[w*128 +: 128] = FIPS_PT;
      req_key[w*128 +: 128]  = FIPS_KEY;
    end
    pt = req_data[w*128 +: 128];
    key = req_key[w*128 +: 128];
    exp_ct = cipher(pt, key);
    eg = '0;
    eg[w] = 1'b1;
    req = r;
    rsp_ready = (hold == 0);
    #1;
    gseen = gnt;
    chk("gnt", 128'(gnt), 128'(eg));
    gcyc = cyc;
    ptr_m = (w + 1) % NREQ;
    got = 1'b0;
    lat = 0;
    starts = 0;
    for (int unsigned n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (drop) req[w] = 1'b0;
        rand_inputs();
      end
      #1;
      chk("core_in_held", core_in, pt);
      chk("core_key_held", core_key, key);
      if (rsp_valid) begin
        got = 1'b1;
        lat = n;
      end else begin
        chk("gnt_while_busy", 128'(gnt), '0);
        if (core_start) starts++;
      end
    end
    chk("rsp_seen", 128'(got), 128'(1'b1));
    chk("latency", 128'(lat), 128'(13));
    chk("start_cycles", 128'(starts), 128'(11));
    chk("rsp_data", rsp_data, exp_ct);
    chk("rsp_id", 128'(rsp_id), 128'(w));
    chk("rsp_err", 128'(rsp_err), '0);
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 128'(rsp_valid), 128'(1'b1));
      chk("hold_data", rsp_data, exp_ct);
      chk("hold_id", 128'(rsp_id), 128'(w));
      chk("hold_gnt", 128'(gnt), '0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_ready", 128'(rsp_valid), '0);
  endtask

  initial begin
    int unsigned g0, g1, n_to;
    logic [NREQ-1:0] gs, r;
    bit seen;
    rstn = 1'b0;
    req = '0;
    req_data = '0;
    req_key = '0;
    rsp_ready = 1'b1;
    stuck = 1'b0;

    // FIPS-197 single job from requester 1
    do_reset('0);
    do_job(4'b0010, 0, 1'b1, 1'b1, g0, gs);
    chk("fips_ct", rsp_data, FIPS_CT);
    req = '0;

    // All requests held through reset: order 0,1,2,3,0 at 14-cycle spacing
    do_reset('1);
    g0 = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      do_job('1, 0, 1'b0, 1'b0, g1, gs);
      r = '0;
      r[k % NREQ] = 1'b1;
      chk("rr_order", 128'(gs), 128'(r));
      if (k > 0) chk("rr_spacing", 128'(g1 - g0), 128'(14));
      g0 = g1;
    end
    req = '0;

    // Backpressure with another requester pending
    do_job(4'b1001, 20, 1'b1, 1'b0, g0, gs);

    for (int unsigned k = 0; k < 10; k++) begin
      r = NREQ'($urandom_range(1, 15));
      do_job(r, $urandom_range(0, 3), 1'b1, 1'b0, g0, gs);
    end
    req = '0;

    // Reset at RUN cycle 5
    rand_inputs();
    req = 4'b0100;
    #1;
    chk("mid_gnt", 128'(gnt), 128'(4'b0100));
    for (int unsigned n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) req = '0;
    end
    #1;
    chk("mid_run_start", 128'(core_start), 128'(1'b1));
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_start", 128'(core_start), '0);
    chk("mid_rst_valid", 128'(rsp_valid), '0);
    chk("mid_rst_core_in", core_in, '0);
    rstn = 1'b1;
    ptr_m = 0;
    do_job(4'b1000, 0, 1'b1, 1'b0, g0, gs);
    req = '0;

    // Core done stuck low
    stuck = 1'b1;
    rand_inputs();
    req = 4'b0001;
    #1;
    chk("to_gnt", 128'(gnt), 128'(4'b0001));
    seen = 1'b0;
    n_to = 0;
    for (int unsigned n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) req = '0;
      #1;
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        n_to = n;
        chk("to_err", 128'(rsp_err), 128'(1'b1));
        chk("to_data", rsp_data, '0);
      end
    end
`ifdef AES_ARB_TIMEOUT_EN
    chk("to_rsp_seen", 128'(seen), 128'(1'b1));
    chk("to_latency", 128'(n_to), 128'(17));
`else
    chk("no_rsp_when_stuck", 128'(seen), '0);
    chk("still_running", 128'(core_start), 128'(1'b1));
`endif
    stuck = 1'b0;
    do_reset('0);
    do_job(4'b0100, 1, 1'b1, 1'b0, g0, gs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_job_arbiter.md
# aes_job_arbiter

Round-robin arbiter that shares one AES-128 encryption core between `NREQ` requesters. It latches the winning requester's plaintext and key and drives the core's context `start` line for exactly one encryption. It detects completion, captures the ciphertext and returns it to the owner over a valid/ready response channel. It sits between the client ports and the AES context/core pair, and it is the only block that drives `start`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 16: RUN-state cycle limit; used only with the timeout feature.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: synchronous, active-low reset, sampled on `clk`.
- `req`  in  NREQ: request level per requester; held until granted.
- `req_data`  in  NREQ*128: plaintexts, requester i at bits [128i+127:128i].
- `req_key`  in  NREQ*128: keys, same packing.
- `gnt`  out  NREQ: one-hot, one-cycle pulse; request accepted and inputs latched.
- `core_start`  out  1: to the context `start` line.
- `core_in`  out  128: latched plaintext to the core.
- `core_key`  out  128: latched key to the core.
- `core_done`  in  1: context `done`.
- `core_out`  in  128: core ciphertext.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: consumer accepts response.
- `rsp_id`  out  3: index of the owning requester.
- `rsp_data`  out  128: ciphertext.
- `rsp_err`  out  1: timeout abort flag.

## Operation
- States: IDLE, RUN, RESP.
- IDLE:
  - If any `req` bit is set, choose the winner round-robin, starting the search at `ptr`.
  - Pulse `gnt[winner]`, latch `req_data`/`req_key` into `core_in`/`core_key`, set `rsp_id` = winner and `ptr` = winner+1 mod NREQ.
  - Go to RUN.
- RUN:
  - `core_start` = 1 AND NOT (`core_done` AND `run_cnt`≠0). This is a combinational gate so the context does not start a second job.
  - `run_cnt` counts RUN cycles from 0.
  - `core_done` is ignored when `run_cnt`=0, because it is stale from the previous job. The context only updates `done` while `start` is high.
  - When `core_done`=1 and `run_cnt`≠0: capture `core_out` into `rsp_data`, clear `rsp_err`, go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data`, `rsp_id` and `rsp_err` are held stable.
  - When `rsp_ready`=1: go to IDLE.
- `core_in` and `core_key` are stable from the grant until the next grant.
- `req` bits that are not granted are ignored in RUN and RESP. No new grant is issued until the state returns to IDLE.
- Reset values: state=IDLE, `ptr`=0, `gnt`=0, `core_start`=0, `core_in`=0, `core_key`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `run_cnt`=0.
- Reset mid-operation: all state returns to IDLE on the next edge and any in-flight job is dropped. The context shares `rstn`, so its round counter is cleared at the same edge.

## Timing
- Cycle G, IDLE with a request: `gnt` pulses and the job is latched.
- G+1 … G+11, RUN: `core_start`=1; the context round counter steps 0→1…10→0.
- G+12, RUN: `core_done`=1 is observed, `core_start` is gated to 0, and `rsp_data` is captured.
- G+13: `rsp_valid`=1. With `rsp_ready` already high, the arbiter is back in IDLE at G+14.
- Grant to response: 13 cycles. Best-case throughput: one job per 14 cycles.
- Round-robin: a requester that holds `req` waits at most NREQ−1 other jobs.
- Simultaneous events:
  - `req` asserted in the same cycle as RESP completes: not granted until the following IDLE cycle.
  - `rsp_ready` high before `rsp_valid`: allowed; the transfer happens on the first valid cycle.

## Configuration
- Macro: `AES_ARB_TIMEOUT_EN`.
- Defined:
  - If `run_cnt` reaches `TIMEOUT` without a qualified `core_done`: drop `core_start`, set `rsp_data`=0 and `rsp_err`=1, go to RESP.
  - The next grant starts a fresh job.
- Undefined:
  - The arbiter waits in RUN indefinitely.
  - `rsp_err` is tied to 0 and the `TIMEOUT` parameter is unused.

## Test plan
- Reset, then a single request: `req`=4'b0010 with FIPS-197 key 000102…0f and plaintext 00112233…ff. Expect `gnt`=4'b0010 at G, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a at G+13, `rsp_id`=1, `rsp_err`=0.
- All four `req` held continuously from reset: grant order 0,1,2,3,0 with grants spaced 14 cycles apart; every `rsp_id` matches its grant.
- Stale done: two back-to-back jobs. The second job's RUN lasts exactly 12 cycles and `core_start` is high for exactly 11 of them.
- Backpressure: `rsp_ready`=0 for 20 cycles. `rsp_valid` and `rsp_data` stay stable, no `gnt` pulses, and IDLE is entered one cycle after `rsp_ready` rises.
- Reset asserted at RUN cycle 5: next edge has state IDLE, `core_start`=0, `rsp_valid`=0. The next job after release completes correctly.
- With `AES_ARB_TIMEOUT_EN` and a core model whose `done` is stuck at 0: `rsp_valid`=1 with `rsp_err`=1 and `rsp_data`=0 after 16 RUN cycles. Without the macro: no response after 100 cycles.
